// File: rtl/iter_shifter_pkg.sv
// Shared definitions for the iterative shift/rotate unit: mode encodings and FSM states.
package iter_shifter_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/iter_shifter_shift_stage.sv
// One log-shifter stage: shifts or rotates data by 2^idx in the selected mode.
module shift_stage
    import iter_shifter_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   data,
    input  logic [1:0]         op,
    input  logic               fill,
    input  logic [SHAMT_W-1:0] idx,
    output logic [WIDTH-1:0]   shifted_c
);

    localparam int unsigned AW = SHAMT_W + 1;

    logic [SHAMT_W-1:0] amt;
    logic [AW-1:0]      wrap_amt;
    logic [WIDTH-1:0]   hi_mask;

    always_comb begin
        amt      = SHAMT_W'(1) << idx;
        // amt is never zero, so the wrap distance stays below WIDTH
        wrap_amt = AW'(WIDTH) - AW'(amt);
        hi_mask  = ~({WIDTH{1'b1}} >> amt);
        case (op)
            OP_SLL:  shifted_c = data << amt;
            OP_SRL:  shifted_c = data >> amt;
            OP_SRA:  shifted_c = (data >> amt) | (fill ? hi_mask : '0);
            default: shifted_c = (data >> amt) | (data << wrap_amt);
        endcase
    end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shift/rotate unit: resolves one log-shifter stage per clock with early exit,
// valid/ready handshake on both sides.
module iter_shifter
    import iter_shifter_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               busy
);

    state_t             state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic [SHAMT_W-1:0] rem;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   stage_c;
    logic [WIDTH-1:0]   out_data_d;
    logic [1:0]         op_q, op_d;
    logic               sign_q, sign_d;
    logic               out_valid_d;
    logic               busy_d;
    logic               accept;
    logic               last;

    // in_ready is a decode of the state register, held low while reset is asserted
    assign in_ready = (state_q == IDLE) && !reset;
    assign accept   = in_valid && in_ready;

    // rem[0] selects this stage; the remaining upper bits decide early exit
    assign rem  = shamt_q >> cnt_q;
    assign last = (cnt_q == SHAMT_W'(SHAMT_W - 1)) || ((rem >> 1) == '0);

    shift_stage #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_stage (
        .data      (work_q),
        .op        (op_q),
        .fill      (sign_q),
        .idx       (cnt_q),
        .shifted_c (stage_c)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shamt_q   <= '0;
            work_q    <= '0;
            op_q      <= OP_SLL;
            sign_q    <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shamt_q   <= shamt_d;
            work_q    <= work_d;
            op_q      <= op_d;
            sign_q    <= sign_d;
            out_data  <= out_data_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shamt_d     = shamt_q;
        work_d      = work_q;
        op_d        = op_q;
        sign_d      = sign_q;
        out_data_d  = out_data;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    work_d  = in_data;
                    shamt_d = in_shamt;
                    op_d    = in_op;
                    sign_d  = in_data[WIDTH-1];
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                work_d = rem[0] ? stage_c : work_q;
                if (last) begin
                    out_data_d = work_d;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q + SHAMT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

endmodule

// File: tb/tb_iter_shifter.sv
// Directed and randomized bench for iter_shifter against an arithmetic reference model.
module tb_iter_shifter;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int tests = 0;
    int fails = 0;

    iter_shifter #(.WIDTH(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input logic [1:0] op);
        case (op)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return 32'($signed(d) >>> s);
            default: return (s == 0) ? d : ((d >> s) | (d << (32 - s)));
        endcase
    endfunction

    function automatic int ref_latency(input int s);
        int hb;
        hb = 0;
        for (int i = 0; i < 5; i++) if (((s >> i) & 1) == 1) hb = i;
        return hb + 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Waits up to a bound for out_valid; returns edges counted.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    // Full transaction: accept, latency, result, drain.
    task automatic run_op(input string tag, input logic [31:0] d, input int s, input logic [1:0] op);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = 5'(s);
        in_op    = op;
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_data  = $urandom;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_valid(n);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_lat"}, 32'(n), 32'(ref_latency(s)));
        check({tag, "_data"}, out_data, ref_shift(d, s, op));
        check({tag, "_inrdy_done"}, 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_drain"}, 32'(out_valid), 32'd0);
        check({tag, "_keep"}, out_data, ref_shift(d, s, op));
    endtask

    initial begin
        int n;
        logic [31:0] d;
        int s;
        logic [1:0] op;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_op     = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        tick();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        run_op("sll31", 32'h0000_0001, 31, 2'b00);
        check("sll31_abs", out_data, 32'h8000_0000);
        run_op("sra4", 32'h8000_0000, 4, 2'b10);
        check("sra4_abs", out_data, 32'hF800_0000);
        run_op("srl4", 32'h8000_0000, 4, 2'b01);
        check("srl4_abs", out_data, 32'h0800_0000);
        run_op("ror4", 32'h0000_00F1, 4, 2'b11);
        check("ror4_abs", out_data, 32'h1000_000F);
        run_op("ror1", 32'h8000_0001, 1, 2'b11);
        check("ror1_abs", out_data, 32'hC000_0000);

        // Result held under back-pressure while a new operand waits
        in_valid = 1'b1;
        in_data  = 32'h1234_5678;
        in_shamt = 5'd0;
        in_op    = 2'b10;
        tick();
        in_data  = 32'hDEAD_BEEF;
        tick();
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data0", out_data, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_data", out_data, 32'h1234_5678);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hold_drain_valid", 32'(out_valid), 32'd0);
        check("hold_drain_busy", 32'(busy), 32'd0);
        check("hold_drain_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("second_taken", 32'(busy), 32'd1);
        wait_valid(n);
        check("second_data", out_data, 32'hDEAD_BEEF);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Back-to-back with out_ready tied high
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h1;
        in_shamt  = 5'd1;
        in_op     = 2'b00;
        tick();
        in_shamt = 5'd2;
        tick();
        check("b2b_first_valid", 32'(out_valid), 32'd1);
        check("b2b_first_data", out_data, 32'h2);
        tick();
        check("b2b_gap_in_ready", 32'(in_ready), 32'd1);
        check("b2b_gap_valid", 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        check("b2b_second_taken", 32'(in_ready), 32'd0);
        tick();
        check("b2b_mid_valid", 32'(out_valid), 32'd0);
        tick();
        check("b2b_second_valid", 32'(out_valid), 32'd1);
        check("b2b_second_data", out_data, 32'h4);
        tick();
        out_ready = 1'b0;
        check("b2b_end_in_ready", 32'(in_ready), 32'd1);

        // Reset in the second SHIFT cycle discards the operation
        in_valid = 1'b1;
        in_data  = 32'h1;
        in_shamt = 5'd31;
        in_op    = 2'b00;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_out_data", out_data, 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("midrst_release_in_ready", 32'(in_ready), 32'd1);
        run_op("fresh_sll3", 32'h1, 3, 2'b00);
        check("fresh_sll3_abs", out_data, 32'h8);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            d  = $urandom;
            s  = int'($urandom_range(0, 31));
            op = 2'($urandom_range(0, 3));
            run_op("rand", d, s, op);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
